// File: rtl/shift_arbiter.sv
// shift_arbiter: one 32-bit shift unit (SLL/SRL/ROTL/SRA) shared by two
// requesters with round-robin grant. A result is held until its owner takes it.
module shift_arbiter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_rt,
    input  logic [SHW-1:0]   req0_shamt,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [WIDTH-1:0] resp0_rd,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_rt,
    input  logic [SHW-1:0]   req1_shamt,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp1_rd,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t           state;
    logic             prio;
    logic             owner;
    logic [WIDTH-1:0] result;

    logic             gnt;
    logic             gnt_valid;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_rt;
    logic [SHW-1:0]   sel_shamt;
    logic             owner_ready;

    // Shift unit. ROTL takes the upper half of the doubled operand shifted left,
    // so bits leaving the MSB reappear at bit 0 without a separate right shift.
    function automatic logic [WIDTH-1:0] do_shift(input logic [1:0]       op,
                                                  input logic [WIDTH-1:0] rt,
                                                  input logic [SHW-1:0]   sh);
        logic signed [WIDTH-1:0] srt;
        logic [2*WIDTH-1:0]      dbl;
        srt = rt;
        dbl = {rt, rt} << sh;
        case (op)
            2'b00:   return rt << sh;
            2'b01:   return rt >> sh;
            2'b10:   return dbl[2*WIDTH-1:WIDTH];
            default: return srt >>> sh;
        endcase
    endfunction

    // Grant selection: a lone requester wins outright, a tie goes to prio.
    // Held off while in reset so nothing looks accepted on a reset edge.
    always_comb begin
        gnt       = (req0_valid && req1_valid) ? prio : req1_valid;
        gnt_valid = rst_n && (state == IDLE) && (req0_valid || req1_valid);
        sel_op    = gnt ? req1_op    : req0_op;
        sel_rt    = gnt ? req1_rt    : req0_rt;
        sel_shamt = gnt ? req1_shamt : req0_shamt;
    end

    assign req0_ready  = gnt_valid && !gnt;
    assign req1_ready  = gnt_valid && gnt;
    assign owner_ready = owner ? resp1_ready : resp0_ready;
    assign resp0_rd    = resp0_valid ? result : '0;
    assign resp1_rd    = resp1_valid ? result : '0;

    // Arbitration FSM: capture the shifted result on a grant, release it when
    // the owner accepts; prio moves to the other requester on each completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            prio        <= 1'b0;
            owner       <= 1'b0;
            result      <= '0;
            busy        <= 1'b0;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        result      <= do_shift(sel_op, sel_rt, sel_shamt);
                        owner       <= gnt;
                        state       <= RESP;
                        busy        <= 1'b1;
                        resp0_valid <= !gnt;
                        resp1_valid <= gnt;
                    end
                end
                default: begin
                    if (owner_ready) begin
                        state       <= IDLE;
                        prio        <= ~owner;
                        busy        <= 1'b0;
                        resp0_valid <= 1'b0;
                        resp1_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one 32-bit shift datapath (SLL/SRL/SRA/ROTL) between two requesters, e.g. the ALU shift path and the load/store byte-alignment path.
- Valid/ready request and response channels per requester.
- Round-robin grant; result held in a register until the owning requester accepts it.
- Throughput: one operation per two cycles at best. Sits beside the ALU in the execute stage.

Parameters:
- WIDTH, 32, data width of rt/rd.
- SHW, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_op  input  2  00 SLL, 01 SRL, 10 ROTL, 11 SRA.
- req0_rt  input  WIDTH  operand.
- req0_shamt  input  SHW  shift amount.
- resp0_valid  output  1  result for requester 0 is available.
- resp0_ready  input  1  requester 0 takes the result.
- resp0_rd  output  WIDTH  result.
- req1_valid, req1_ready, req1_op, req1_rt, req1_shamt, resp1_valid, resp1_ready, resp1_rd: same as requester 0.
- busy  output  1  high when state is RESP.

Behaviour:
- Clocking/reset: one clock domain. All state updates on rising clk. rst_n low at an edge forces reset state regardless of activity.
- Reset values: state=IDLE, prio=0, owner=0, result=0; all ready/valid outputs 0; both resp rd = 0; busy=0.
- FSM, IDLE:
  - grant = req0 if only req0_valid; req1 if only req1_valid; if both, grant = prio.
  - reqN_ready = 1 (combinational) for the granted N only; 0 for the other; both 0 if neither valid.
  - On handshake: result <= shift(op, rt, shamt); owner <= N; state <= RESP.
- FSM, RESP:
  - respN_valid = 1 for N = owner only.
  - Both req_ready = 0; new requests wait and must hold their inputs stable.
  - When resp_ready of owner = 1: state <= IDLE, prio <= ~owner.
  - resp_ready of the non-owner is ignored.
- Latency: handshake at cycle T gives resp_valid from T+1. Earliest next accept is T+2 (resp_ready at T+1).
- respN_rd: equals result when owner==N and in RESP, else 0.
- Shift arithmetic, width WIDTH, shamt unsigned 0..WIDTH-1:
  - SLL: zero fill from bit 0.
  - SRL: zero fill from MSB.
  - SRA: replicate rt[WIDTH-1].
  - ROTL: bits leaving the MSB re-enter at bit 0.
  - shamt=0 returns rt unchanged for all ops.
- Fairness: prio flips only on completed response. A single active requester is served back-to-back. With both continuously valid, grants alternate 0,1,0,1 starting from prio.
- Reset mid-operation: a pending result is discarded, resp_valid drops the cycle after the reset edge, prio returns to 0.
- Valid without ready: a requester may deassert valid before acceptance (no state effect). Inputs are sampled only at the handshake edge.

Test Plan:
- Reset: rst_n=0 two cycles with req0_valid=1 -> all ready/valid=0, busy=0; after release with req0_valid=1 -> req0_ready=1 in first IDLE cycle.
- Ops on requester 0, rt=0x805C9BD2, shamt=4, resp0_ready=1 -> results SLL 0x05C9BD20, SRL 0x0805C9BD, SRA 0xF805C9BD, ROTL 0x05C9BD28; each resp0_valid exactly one cycle after its handshake.
- Boundaries, rt=0x805C9BD2: SLL/SRL/SRA/ROTL shamt=0 -> 0x805C9BD2; SLL 1 -> 0x00B937A4; SLL 31 -> 0x00000000; SRA 31 -> 0xFFFFFFFF; SRL 31 -> 0x00000001.
- Contention: both valid continuously for 4 operations, resp ready tied 1 -> grant order 0,1,0,1; req ready never high on both in one cycle; respN_valid only for owner.
- Backpressure: resp1_ready=0 for 5 cycles after grant to req1 -> resp1_valid and resp1_rd stable, busy=1, req0_ready=0 throughout; resp1_ready=1 -> IDLE next cycle, req0 granted.
- Reset mid-RESP: assert rst_n=0 while resp0_valid=1 and resp0_ready=0 -> resp0_valid=0 after the edge; post-reset with both valid, req0 granted first.
